// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types: fetch FSM states, the IF/ID record and the NOP encoding.
// Decode imports ifid_t from here.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StTrap
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: asynchronous reset to RESET_PC, load takes priority over the +4 advance.
module pc_reg #(
    parameter int unsigned PC_W     = 9,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4
);

    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC[PC_W-1:0];
        end else if (load) begin
            pc_q <= load_pc;
        end else if (en) begin
            pc_q <= pc_plus4;
        end
    end

    assign pc       = pc_q;
    // Wraps modulo 2^PC_W by construction.
    assign pc_plus4 = pc_q + PC_W'(4);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/next-PC selection, IF/ID register and BOOT/RUN sequencing.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirects instead of forcing alignment.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned PC_W     = 9,
    parameter int unsigned INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               PcSel,
    input  logic [31:0]        BrPC,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic               fetch_misalign,
`endif
    output logic [PC_W-1:0]    pc_plus4
);

    localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

    fetch_state_t    state_q, state_d;
    ifid_t           ifid_q, ifid_d, ifid_fetch;
    logic [PC_W-1:0] pc;
    logic            pc_en;
    logic            pc_load;
    logic [PC_W-1:0] load_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
`endif

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (pc_en),
        .load     (pc_load),
        .load_pc  (load_pc),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign ifid_fetch = '{pc: XLEN'(pc), instr: XLEN'(imem_rdata), valid: 1'b1};

    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_q;
        pc_en   = 1'b0;
        pc_load = 1'b0;
        load_pc = {BrPC[PC_W-1:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            StBoot: begin
                if (!stall) begin
                    pc_en   = 1'b1;
                    ifid_d  = ifid_fetch;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Redirect beats stall so the wrong-path instruction never reaches decode.
                if (PcSel) begin
                    pc_load = 1'b1;
                    ifid_d  = IFID_BUBBLE;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (BrPC[1:0] != 2'b00) begin
                        load_pc    = BrPC[PC_W-1:0];
                        misalign_d = 1'b1;
                        state_d    = StTrap;
                    end
`endif
                end else if (!stall) begin
                    pc_en  = 1'b1;
                    ifid_d = ifid_fetch;
                end
            end
            // StTrap holds everything until reset.
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StBoot;
            ifid_q  <= IFID_BUBBLE;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign = misalign_q;
`endif

    assign imem_addr  = pc;
    assign ifid_pc    = ifid_q.pc[PC_W-1:0];
    assign ifid_instr = ifid_q.instr[INSTR_W-1:0];
    assign ifid_valid = ifid_q.valid;

    // BrPC upper bits are truncated by design; low bits only matter with the trap enabled.
    logic unused_bits;
    assign unused_bits = ^{BrPC[31:PC_W], BrPC[1:0], ifid_q.pc[XLEN-1:PC_W]};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, wrap, redirect, stall, truncation, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        PcSel;
    logic [31:0] BrPC;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [8:0]  ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [8:0]  pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int tests = 0;
    int fails = 0;

    fetch_stage #(
        .PC_W     (9),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .PcSel          (PcSel),
        .BrPC           (BrPC),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .ifid_valid     (ifid_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .pc_plus4       (pc_plus4)
    );

    // Address-encoded instruction memory.
    assign imem_rdata = 32'hC000_0000 | {23'b0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        PcSel = 1'b0;
        BrPC  = 32'h0;
        step();
        step();

        check("rst_addr",  imem_addr, 32'h000);
        check("rst_p4",    pc_plus4, 32'h004);
        check("rst_pc",    ifid_pc, 32'h000);
        check("rst_instr", ifid_instr, 32'h0000_0013);
        check("rst_valid", ifid_valid, 32'h0);

        reset = 1'b1;
        step();
        check("boot_pc",    ifid_pc, 32'h000);
        check("boot_instr", ifid_instr, 32'hC000_0000);
        check("boot_valid", ifid_valid, 32'h1);
        check("boot_addr",  imem_addr, 32'h004);
        step();
        check("seq1_pc",   ifid_pc, 32'h004);
        check("seq1_addr", imem_addr, 32'h008);
        check("seq1_p4",   pc_plus4, 32'h00C);
        step();
        check("seq2_pc",   ifid_pc, 32'h008);
        check("seq2_addr", imem_addr, 32'h00C);
        check("seq2_p4",   pc_plus4, 32'h010);
        step();
        check("seq3_pc",   ifid_pc, 32'h00C);
        check("seq3_addr", imem_addr, 32'h010);

        // Redirect at PC = 0x10.
        PcSel = 1'b1;
        BrPC  = 32'h0000_0040;
        step();
        PcSel = 1'b0;
        check("br_addr",  imem_addr, 32'h040);
        check("br_valid", ifid_valid, 32'h0);
        check("br_instr", ifid_instr, 32'h0000_0013);
        check("br_pc",    ifid_pc, 32'h000);
        step();
        check("br2_pc",    ifid_pc, 32'h040);
        check("br2_valid", ifid_valid, 32'h1);
        check("br2_instr", ifid_instr, 32'hC000_0040);
        check("br2_addr",  imem_addr, 32'h044);

        // Get to PC = 0x20 with a real instruction in IF/ID, then stall.
        PcSel = 1'b1;
        BrPC  = 32'h0000_001C;
        step();
        PcSel = 1'b0;
        step();
        check("pre_stall_addr", imem_addr, 32'h020);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  imem_addr, 32'h020);
            check("stall_pc",    ifid_pc, 32'h01C);
            check("stall_instr", ifid_instr, 32'hC000_001C);
            check("stall_valid", ifid_valid, 32'h1);
        end
        PcSel = 1'b1;
        BrPC  = 32'h0000_0080;
        step();
        PcSel = 1'b0;
        stall = 1'b0;
        check("stbr_addr",  imem_addr, 32'h080);
        check("stbr_valid", ifid_valid, 32'h0);
        check("stbr_instr", ifid_instr, 32'h0000_0013);

        // Wrap from 0x1FC to 0x000.
        PcSel = 1'b1;
        BrPC  = 32'h0000_01F8;
        step();
        PcSel = 1'b0;
        step();
        check("pre_wrap_addr", imem_addr, 32'h1FC);
        check("pre_wrap_p4",   pc_plus4, 32'h000);
        step();
        check("wrap_addr",  imem_addr, 32'h000);
        check("wrap_pc",    ifid_pc, 32'h1FC);
        check("wrap_valid", ifid_valid, 32'h1);
        check("wrap_instr", ifid_instr, 32'hC000_01FC);
        check("wrap_p4",    pc_plus4, 32'h004);

        // Truncated, misaligned redirect.
        PcSel = 1'b1;
        BrPC  = 32'hFFFF_0106;
        step();
        PcSel = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_addr",  imem_addr, 32'h106);
        check("mis_flag",  fetch_misalign, 32'h1);
        check("mis_valid", ifid_valid, 32'h0);
        step();
        step();
        check("trap_addr",  imem_addr, 32'h106);
        check("trap_flag",  fetch_misalign, 32'h1);
        check("trap_valid", ifid_valid, 32'h0);
`else
        check("mis_addr",  imem_addr, 32'h104);
        check("mis_valid", ifid_valid, 32'h0);
        step();
        check("mis2_addr",  imem_addr, 32'h108);
        check("mis2_pc",    ifid_pc, 32'h104);
        check("mis2_valid", ifid_valid, 32'h1);
`endif

        // Asynchronous reset between edges.
        #3;
        reset = 1'b0;
        #1;
        check("arst_addr",  imem_addr, 32'h000);
        check("arst_pc",    ifid_pc, 32'h000);
        check("arst_instr", ifid_instr, 32'h0000_0013);
        check("arst_valid", ifid_valid, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("arst_flag",  fetch_misalign, 32'h0);
`endif
        stall = 1'b1;
        #2;
        reset = 1'b1;
        step();
        step();
        check("bstall_addr",  imem_addr, 32'h000);
        check("bstall_valid", ifid_valid, 32'h0);
        stall = 1'b0;
        step();
        check("reboot_pc",    ifid_pc, 32'h000);
        check("reboot_valid", ifid_valid, 32'h1);
        check("reboot_instr", ifid_instr, 32'hC000_0000);
        check("reboot_addr",  imem_addr, 32'h004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the branch unit.
- Owns the program counter and the next-PC selection: PC+4, or the redirect target (BrPC when PcSel is high).
- Drives the instruction-memory address and holds the IF/ID pipeline register (pc, instr, valid) that feeds decode.
- Cur_PC reaches the branch unit through the later pipeline stages.

Parameters:
- PC_W, 9, program-counter width in bits; byte address, instruction memory depth 2^PC_W bytes.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned and fit in PC_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit hold; freezes PC and IF/ID.
- PcSel  input  1  redirect request from branch unit (taken branch/jal/jalr).
- BrPC  input  32  redirect target from branch unit.
- imem_addr  output  PC_W  instruction-memory read address; equals current PC.
- imem_rdata  input  INSTR_W  combinational instruction-memory read data for imem_addr.
- ifid_pc  output  PC_W  PC of the instruction in IF/ID.
- ifid_instr  output  INSTR_W  instruction in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- pc_plus4  output  PC_W  current PC + 4, for observability and link.

Behaviour:
- Reset (reset low, asynchronous):
  - PC = RESET_PC; ifid_pc = 0; ifid_instr = 32'h00000013 (NOP); ifid_valid = 0; FSM = BOOT.
  - Reset asserted mid-run discards all in-flight state immediately.
- FSM has 2 states, BOOT and RUN.
  - BOOT: the first edge after reset release fetches RESET_PC. IF/ID captures that instruction with valid = 1. PC becomes RESET_PC+4. Go to RUN.
  - BOOT exists so the first fetch is never lost to a reset/stall race. A stall in BOOT holds BOOT.
  - RUN: normal operation; never returns to BOOT except by reset.
- Next-PC priority, evaluated each edge in RUN:
  1. PcSel = 1:
     - PC = BrPC[PC_W-1:0]; upper bits of BrPC are ignored (truncation).
     - IF/ID is flushed: valid = 0, instr = NOP, pc = 0.
     - Redirect wins over stall in the same cycle; the wrong-path instruction must never reach decode.
  2. stall = 1: PC and IF/ID hold their values.
  3. Otherwise: PC = PC + 4, modulo 2^PC_W (wraps to 0 from 2^PC_W-4). IF/ID captures {PC, imem_rdata, valid = 1}.
- Latency:
  - The redirect target appears on imem_addr one cycle after PcSel.
  - Its instruction is valid in IF/ID two cycles after PcSel.
  - Redirect penalty is therefore 1 bubble in IF/ID, plus whatever downstream stages flush.
- Timing of ports:
  - imem_addr and pc_plus4 are combinational from the PC register.
  - All IF/ID outputs are registered.
- Misaligned BrPC (bits [1:0] non-zero) without the optional feature: bits [1:0] are forced to 0 before loading PC.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_misalign (1 bit, registered, reset 0).
  - A redirect with BrPC[1:0] != 0 sets fetch_misalign = 1 and loads PC = BrPC with no forcing.
  - IF/ID stays flushed (valid = 0) until reset.
  - The FSM gains a TRAP state, in which PC and IF/ID hold regardless of stall/PcSel. TRAP exits only via reset.
- When not defined: no port, no TRAP state, forced alignment as above.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant (32'h00000013).
  - fetch_state_t enum (BOOT, RUN, TRAP).
  - ifid_t struct {pc, instr, valid}, reused by decode.
- One natural sub-module: pc_reg, the PC register with async reset, enable, and load.
- The IF/ID register and FSM stay in fetch_stage.

Test Plan:
- Reset release, no stall, imem returns addr-encoded data:
  - IF/ID valid from the first edge with pc = 0.
  - Then pc = 4, 8, 12 on successive cycles.
  - pc_plus4 always equals imem_addr + 4.
- Run to PC = 0x1FC (PC_W = 9), no stall → next PC = 0x000 (wrap); IF/ID pc = 0x1FC valid.
- PcSel = 1, BrPC = 0x0000_0040 at PC = 0x10:
  - Next cycle imem_addr = 0x040 and IF/ID valid = 0 with NOP.
  - Following cycle IF/ID pc = 0x040, valid = 1.
- stall = 1 for 3 cycles at PC = 0x20 → PC and IF/ID unchanged throughout; stall = 1 with PcSel = 1, BrPC = 0x80 → PC = 0x080 and IF/ID flushed.
- BrPC = 0xFFFF_0106 → PC = 0x104 (truncated, aligned); with FETCH_MISALIGN_TRAP_EN defined → fetch_misalign = 1, PC = 0x106, valid stays 0.
- Assert reset low mid-run, asynchronously between edges → outputs go to reset values immediately; after release, BOOT refetches RESET_PC.
